// File: rtl/serial_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_rx_if
//  Description : Bundle between the serial receiver and its consumer.
//                Carries the idle-high serial line into the receiver and the
//                received word plus its status pulses out of it.
//                  rx_in      - asynchronous serial line (idle high)
//                  data_out   - last correctly framed word
//                  data_valid - one-cycle pulse, data_out updated
//                  frame_err  - one-cycle pulse, stop bit sampled low
//                  busy       - a frame is in progress
//                Modport master: the receiver side.
//                Modport slave : the line driver / word consumer side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_rx_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 rx_in;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  rx_in,
    output data_out,
    output data_valid,
    output frame_err,
    output busy
  );

  modport slave (
    output rx_in,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/serial_rx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_rx
//  Description : Serial-to-parallel receiver. 1 start bit (0), DATA_BITS data
//                bits LSB first, 1 stop bit (1), CLKS_PER_BIT clocks per bit.
//                Each good frame updates data_out with a data_valid pulse;
//                a low stop bit gives a frame_err pulse instead.
//  Ports       : clk   - system clock, all logic on its rising edge
//                rst_n - synchronous active-low reset
//                bus   - serial_rx_if.master (rx_in in; data_out,
//                        data_valid, frame_err, busy out)
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_rx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  serial_rx_if.master bus
);

  localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam int c_IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
  // Start bit is checked at mid-bit; every later sample is a whole bit on.
  localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_BITS - 1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_START = 2'd1;
  localparam logic [1:0] c_ST_DATA  = 2'd2;
  localparam logic [1:0] c_ST_STOP  = 2'd3;

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic                 r_s1;
  logic                 r_rx_s;
  logic                 r_rx_prev;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_IDX_W-1:0]   r_idx;
  logic [DATA_BITS-1:0] r_sr;
  logic [DATA_BITS-1:0] w_sr_next;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_data_valid;
  logic                 r_frame_err;

  logic w_cnt_last;
  logic w_cnt_half;
  logic w_idx_last;
  logic w_fall;
  logic w_busy;
  logic w_start_ok;
  logic w_bit_take;
  logic w_stop_good;
  logic w_stop_bad;

  // Two-flop synchronizer plus a history flop for falling-edge detection.
  // All three reset high so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1      <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_s1      <= bus.rx_in;
      r_rx_s    <= r_s1;
      r_rx_prev <= r_rx_s;
    end
  end

  assign w_cnt_last = (r_cnt == c_CNT_LAST);
  assign w_cnt_half = (r_cnt == c_CNT_HALF);
  assign w_idx_last = (r_idx == c_IDX_LAST);
  assign w_fall     = r_rx_prev & ~r_rx_s;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_fall) w_state_next = c_ST_START;
      c_ST_START: if (w_cnt_half) w_state_next = r_rx_s ? c_ST_IDLE : c_ST_DATA;
      c_ST_DATA:  if (w_cnt_last && w_idx_last) w_state_next = c_ST_STOP;
      c_ST_STOP:  if (w_cnt_last) w_state_next = c_ST_IDLE;
      default:    w_state_next = c_ST_IDLE;
    endcase
  end

  // Output / datapath-control decode
  always_comb begin
    w_busy      = (r_state != c_ST_IDLE);
    w_start_ok  = 1'b0;
    w_bit_take  = 1'b0;
    w_stop_good = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      c_ST_START: w_start_ok  = w_cnt_half & ~r_rx_s;
      c_ST_DATA:  w_bit_take  = w_cnt_last;
      c_ST_STOP: begin
        w_stop_good = w_cnt_last &  r_rx_s;
        w_stop_bad  = w_cnt_last & ~r_rx_s;
      end
      default: ;
    endcase
  end

  // New bit enters at the top so the first bit received ends up in bit 0.
  generate
    if (DATA_BITS > 1) begin : g_sr_wide
      assign w_sr_next = {r_rx_s, r_sr[DATA_BITS-1:1]};
    end else begin : g_sr_single
      assign w_sr_next = r_rx_s;
    end
  endgenerate

  // Counters, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_sr         <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_data_valid <= w_stop_good;
      r_frame_err  <= w_stop_bad;

      // Held at zero while idle so START always begins from a clean count;
      // restarted at the start sample and at every data sample.
      if ((r_state == c_ST_IDLE) || w_start_ok || w_bit_take) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end

      if (w_start_ok) begin
        r_idx <= '0;
      end else if (w_bit_take && !w_idx_last) begin
        r_idx <= r_idx + c_IDX_W'(1);
      end

      if (w_bit_take) begin
        r_sr <= w_sr_next;
      end

      if (w_stop_good) begin
        r_data_out <= r_sr;
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.busy       = w_busy;

endmodule
`default_nettype wire
